// File: rtl/date_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : date_sequencer
// Description : Alternates two fixed six-digit dates (A = 110399, B = 101798)
//               on six seven-segment code outputs. A blank interval separates
//               every change of date. Dates advance on a timed dwell (auto
//               mode) or on a pushbutton press (either mode).
//               Optional pushbutton debounce: define
//               DATE_SEQUENCER_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module date_sequencer #(
    parameter int DWELL_CYCLES    = 50000000,
    parameter int BLANK_CYCLES    = 5000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       btn_next_n,
    input  logic       mode_auto,
    output logic [4:0] d5,
    output logic [4:0] d4,
    output logic [4:0] d3,
    output logic [4:0] d2,
    output logic [4:0] d1,
    output logic [4:0] d0,
    output logic       sel,
    output logic       blanking
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The dwell counter serves both SHOW and BLANK, so it is sized for the
    // longer of the two. It never counts past (duration - 1), so it cannot wrap.
    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    // Digit images, d5 in the most significant field
    localparam logic [29:0] DATE_A     = {5'd1, 5'd1, 5'd0, 5'd3, 5'd9, 5'd9};
    localparam logic [29:0] DATE_B     = {5'd1, 5'd0, 5'd1, 5'd7, 5'd9, 5'd8};
    localparam logic [29:0] BLANK_CODE = {6{5'h1F}};

    // Reject degenerate durations at elaboration rather than building a
    // counter that compares against a negative terminal value.
    if (DWELL_CYCLES < 1 || BLANK_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("date_sequencer: all cycle parameters must be >= 1");
    end

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Input conditioning: synchronizers, arming, optional debounce, edge detect
    // ------------------------------------------------------------------------
    logic       btn_s1_q,   btn_s1_d;
    logic       btn_s2_q,   btn_s2_d;
    logic       mode_s1_q,  mode_s1_d;
    logic       mode_s2_q,  mode_s2_d;
    logic [1:0] prime_q,    prime_d;
    logic       armed_q,    armed_d;
    logic       btn_prev_q, btn_prev_d;
    logic       btn_level;
    logic       btn_event;

`ifdef DATE_SEQUENCER_DEBOUNCE_EN
    localparam int                DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            btn_db_q, btn_db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    assign btn_level = btn_db_q;
`else
    assign btn_level = btn_s2_q;
`endif

    // A press only counts once a genuine released (high) sample has reached
    // the synchronizer output since reset. The synchronizer flops reset to
    // "released", so without this a button held through reset release would
    // look like a fresh falling edge.
    assign btn_event = armed_q & btn_prev_q & ~btn_level;

    // Next-state of the synchronizers, arming logic, debounce and edge history
    always_comb begin
        btn_s1_d   = btn_next_n;
        btn_s2_d   = btn_s1_q;
        mode_s1_d  = mode_auto;
        mode_s2_d  = mode_s1_q;
        // prime_q[1] is set once btn_s2_q holds a real pin sample, not reset fill
        prime_d    = {prime_q[0], 1'b1};
        armed_d    = armed_q | (prime_q[1] & btn_s2_q);
        btn_prev_d = btn_level;
`ifdef DATE_SEQUENCER_DEBOUNCE_EN
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        // Accept a new level only after it has differed from the accepted
        // level for DEBOUNCE_CYCLES consecutive samples; any return resets.
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
`endif
    end

    // Input-conditioning registers; button-path flops reset to released (1)
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_s1_q   <= 1'b1;
            btn_s2_q   <= 1'b1;
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            prime_q    <= 2'b00;
            armed_q    <= 1'b0;
            btn_prev_q <= 1'b1;
`ifdef DATE_SEQUENCER_DEBOUNCE_EN
            btn_db_q   <= 1'b1;
            db_cnt_q   <= '0;
`endif
        end else begin
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            mode_s1_q  <= mode_s1_d;
            mode_s2_q  <= mode_s2_d;
            prime_q    <= prime_d;
            armed_q    <= armed_d;
            btn_prev_q <= btn_prev_d;
`ifdef DATE_SEQUENCER_DEBOUNCE_EN
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // SHOW / BLANK sequencer
    // ------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sel_q,   sel_d;

    // Next-state: a press always wins over dwell expiry, so a coincident
    // press and expiry produce exactly one BLANK and one sel toggle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_SHOW: begin
                if (btn_event) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end else if (mode_s2_q) begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Manual mode: no dwell in progress
                    cnt_d = '0;
                end
            end
            ST_BLANK: begin
                // Presses here are dropped; BLANK always runs to completion
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    sel_d   = ~sel_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SHOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded purely from registered state and sel
    // ------------------------------------------------------------------------
    logic [29:0] digits;

    // Select the digit image for the current state and date index
    always_comb begin
        digits = DATE_A;
        if (state_q == ST_BLANK) begin
            digits = BLANK_CODE;
        end else if (sel_q) begin
            digits = DATE_B;
        end
    end

    assign {d5, d4, d3, d2, d1, d0} = digits;
    assign sel      = sel_q;
    assign blanking = (state_q == ST_BLANK);

endmodule
`default_nettype wire

// File: tb/tb_date_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_date_sequencer
// Description : Scoreboard bench for date_sequencer. The driver advances a
//               behavioural model each clock and queues the expected outputs;
//               a monitor on the falling edge pops and compares.
//               Honours DATE_SEQUENCER_DEBOUNCE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_date_sequencer;

    localparam int DWELL = 10;
    localparam int BLANK = 3;
    localparam int DEB   = 4;

    localparam logic [29:0] DATE_A     = {5'd1, 5'd1, 5'd0, 5'd3, 5'd9, 5'd9};
    localparam logic [29:0] DATE_B     = {5'd1, 5'd0, 5'd1, 5'd7, 5'd9, 5'd8};
    localparam logic [29:0] BLANK_CODE = {6{5'h1F}};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_n;
    logic       mode;
    logic [4:0] d5, d4, d3, d2, d1, d0;
    logic       sel;
    logic       blanking;

    date_sequencer #(
        .DWELL_CYCLES    (DWELL),
        .BLANK_CYCLES    (BLANK),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .btn_next_n (btn_n),
        .mode_auto  (mode),
        .d5         (d5),
        .d4         (d4),
        .d3         (d3),
        .d2         (d2),
        .d1         (d1),
        .d0         (d0),
        .sel        (sel),
        .blanking   (blanking)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic        blanking;
        logic [29:0] digits;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // ------------------------------------------------------------------------
    // Reference model: pin samples are kept as a short history; a sample is
    // "real" only if taken while out of reset. The sequencer sees inputs
    // two clocks late, and a press is a real high followed by a low.
    // Durations are tracked as remaining clocks.
    // ------------------------------------------------------------------------
    bit b_val[$];
    bit b_real[$];
    bit md[$];
    bit seen_high;
    bit db_level, db_prev;
    int db_run;
    bit m_blank, m_sel;
    int m_left;

    function automatic void model_reset();
        m_blank   = 1'b0;
        m_sel     = 1'b0;
        m_left    = DWELL;
        b_val     = '{1'b1, 1'b1, 1'b1};
        b_real    = '{1'b0, 1'b0, 1'b0};
        md        = '{1'b0, 1'b0, 1'b0};
        seen_high = 1'b0;
        db_level  = 1'b1;
        db_prev   = 1'b1;
        db_run    = 0;
    endfunction

    // One rising edge with pin values b/m present at that edge
    function automatic void model_edge(input bit b, input bit m);
        bit lvl, prv, ev, armed, mode_used;
        // history index 0 = sample three clocks ago, 1 = two clocks ago
        seen_high = seen_high | (b_real[0] & b_val[0]);
        armed     = seen_high;
        mode_used = md[1];
`ifdef DATE_SEQUENCER_DEBOUNCE_EN
        lvl     = db_level;
        prv     = db_prev;
        db_prev = db_level;
        if (b_val[1] != db_level) begin
            db_run++;
            if (db_run == DEB) begin
                db_level = b_val[1];
                db_run   = 0;
            end
        end else begin
            db_run = 0;
        end
`else
        lvl = b_val[1];
        prv = b_val[0];
`endif
        ev = armed && prv && !lvl;

        if (!m_blank) begin
            if (ev) begin
                m_blank = 1'b1;
                m_left  = BLANK;
            end else if (mode_used) begin
                m_left--;
                if (m_left == 0) begin
                    m_blank = 1'b1;
                    m_left  = BLANK;
                end
            end else begin
                m_left = DWELL;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_blank = 1'b0;
                m_sel   = ~m_sel;
                m_left  = DWELL;
            end
        end

        b_val.push_back(b);   void'(b_val.pop_front());
        b_real.push_back(1'b1); void'(b_real.pop_front());
        md.push_back(m);      void'(md.pop_front());
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.sel      = m_sel;
        o.blanking = m_blank;
        o.digits   = m_blank ? BLANK_CODE : (m_sel ? DATE_B : DATE_A);
        return o;
    endfunction

    // ------------------------------------------------------------------------
    // Driver: one clock per call; new pin values apply 1 time unit after
    // the edge, so reset assertion takes effect before the monitor samples.
    // ------------------------------------------------------------------------
    task automatic step(input bit b, input bit m, input bit r);
        @(posedge clk);
        if (rst_n) model_edge(btn_n, mode);
        else       model_reset();
        #1;
        btn_n = b;
        mode  = m;
        rst_n = r;
        if (!r) model_reset();
        exp_q.push_back(model_out());
        cycle++;
    endtask

    task automatic idle(input int n, input bit b, input bit m);
        for (int i = 0; i < n; i++) step(b, m, 1'b1);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: outputs are valid every cycle; compare at the falling edge
    // ------------------------------------------------------------------------
    obs_t mon_exp, mon_act;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {sel, blanking, d5, d4, d3, d2, d1, d0};
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got sel=%b blanking=%b digits=%h, expected sel=%b blanking=%b digits=%h",
                             cycle, mon_act.sel, mon_act.blanking, mon_act.digits,
                             mon_exp.sel, mon_exp.blanking, mon_exp.digits);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int  hold;
    bit  rb, rm;

    initial begin
        rst_n = 1'b0;
        btn_n = 1'b1;
        mode  = 1'b0;
        model_reset();

        // Reset state
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // Timed rotation: A, blank, B, blank, A
        idle(40, 1'b1, 1'b1);

        // Manual mode: 5-cycle press, then long quiet period
        idle(5, 1'b1, 1'b0);
        idle(5, 1'b0, 1'b0);
        idle(50, 1'b1, 1'b0);

        // Second press lands inside BLANK and must be dropped
        idle(2, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        idle(20, 1'b1, 1'b0);

        // Short glitch and a longer press (debounce boundary when enabled)
        idle(3, 1'b0, 1'b0);
        idle(20, 1'b1, 1'b0);
        idle(6, 1'b0, 1'b0);
        idle(20, 1'b1, 1'b0);

        // Press swept across the dwell-expiry cycle
        for (int d = 0; d < 15; d++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b1);
            idle(d, 1'b1, 1'b1);
            idle(3, 1'b0, 1'b1);
            idle(22, 1'b1, 1'b1);
        end

        // Reset pulse mid-BLANK with sel=1, button held low through release
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(4, 1'b1, 1'b0);
        idle(8, 1'b0, 1'b0);
        idle(20, 1'b1, 1'b0);
        idle(8, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle(12, 1'b0, 1'b0);
        idle(20, 1'b1, 1'b0);
        idle(6, 1'b0, 1'b0);
        idle(20, 1'b1, 1'b0);

        // Randomised button timing, mode changes and occasional resets
        rb = 1'b1;
        rm = 1'b1;
        for (int n = 0; n < 120; n++) begin
            rb   = ~rb;
            hold = int'($urandom_range(1, 9));
            if ($urandom_range(0, 5) == 0) rm = ~rm;
            if ($urandom_range(0, 30) == 0) step(rb, rm, 1'b0);
            idle(hold, rb, rm);
        end
        idle(30, 1'b1, 1'b1);

        // Drain: every queued expectation must have been consumed
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
